hazard_ctrl: RTL and testbench

- Pipeline sequencing controller for the front end of the 5-stage MIPS core.
- Drives the enable and flush controls of the PC register, the IF/ID register and the ID/EX register.
- Resolves three events: load-use hazards, taken branches resolved in ID, and multi-cycle multiply/divide occupancy.
- Holds two saturating performance counters (stall cycles, branch flushes).

---
 rtl/hazard_ctrl.sv | 112 +++++++++++
 tb/tb_hazard_ctrl.sv | 137 +++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Front-end sequencing controller for the 5-stage MIPS core: resolves load-use,
// taken-branch and mul/div occupancy into PC / IF/ID / ID/EX enables and flushes.
module hazard_ctrl #(
   parameter int MDU_LAT = 32,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic             id_mdu_op,
   input  logic             id_branch_taken,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_wreg,
   input  logic             clr_cnt,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             mdu_busy,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic             dbg_state
);

   typedef enum logic {RUN = 1'b0, MDU_WAIT = 1'b1} state_t;

   localparam logic [7:0]       MDU_LAT_M1 = 8'(MDU_LAT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   state_t     state, state_nxt;
   logic [7:0] mdu_cnt, mdu_cnt_nxt;
   logic       load_use;
   logic       br_flush;

   // $zero is never a real producer, so it can never create a hazard.
   assign load_use = ex_mem_read && (ex_wreg != 5'd0) &&
                     ((id_use_rs && (id_rs == ex_wreg)) ||
                      (id_use_rt && (id_rt == ex_wreg)));

   assign dbg_state = (state == MDU_WAIT);

   always_comb begin
      state_nxt   = state;
      mdu_cnt_nxt = mdu_cnt;
      pc_en       = 1'b1;
      if_id_en    = 1'b1;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      mdu_busy    = 1'b0;
      br_flush    = 1'b0;
      case (state)
         RUN: begin
            if (load_use) begin
               pc_en       = 1'b0;
               if_id_en    = 1'b0;
               id_ex_flush = 1'b1;
            end else begin
               if (id_branch_taken) begin
                  if_id_flush = 1'b1;
                  br_flush    = 1'b1;
               end
               // The mdu op itself advances into EX; the wait starts next cycle.
               if (id_mdu_op) begin
                  state_nxt   = MDU_WAIT;
                  mdu_cnt_nxt = MDU_LAT_M1;
               end
            end
         end
         MDU_WAIT: begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
            mdu_busy    = 1'b1;
            if (mdu_cnt == 8'd0) state_nxt = RUN;
            else                 mdu_cnt_nxt = mdu_cnt - 8'd1;
         end
         default: state_nxt = RUN;
      endcase
      if (!rst) begin
         pc_en       = 1'b0;
         if_id_en    = 1'b0;
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
         mdu_busy    = 1'b0;
         br_flush    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= RUN;
         mdu_cnt   <= 8'd0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         state   <= state_nxt;
         mdu_cnt <= mdu_cnt_nxt;
         if (clr_cnt) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
         end else begin
            if (!pc_en && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + CNT_ONE;
            if (br_flush && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios followed by random traffic, all checked
// against a cycle-level behavioural model of the stall/flush rules.
module tb_hazard_ctrl;

   localparam int MDU_LAT = 4;
   localparam int CNT_W   = 4;
   localparam int CMAX    = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [4:0]       id_rs = '0, id_rt = '0, ex_wreg = '0;
   logic             id_use_rs = 0, id_use_rt = 0, id_mdu_op = 0, id_branch_taken = 0;
   logic             ex_mem_read = 0, clr_cnt = 0;
   logic             pc_en, if_id_en, if_id_flush, id_ex_flush, mdu_busy, dbg_state;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   // model state: remaining wait cycles and the two counters
   int wait_left = 0;
   int m_stall   = 0;
   int m_flush   = 0;

   hazard_ctrl #(.MDU_LAT(MDU_LAT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .id_mdu_op(id_mdu_op), .id_branch_taken(id_branch_taken),
      .ex_mem_read(ex_mem_read), .ex_wreg(ex_wreg), .clr_cnt(clr_cnt),
      .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
      .id_ex_flush(id_ex_flush), .mdu_busy(mdu_busy),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
   endtask

   // One clock cycle: drive inputs after the falling edge, check outputs 1 ns later,
   // then advance the model to what the rising edge will produce.
   task automatic cycle(input logic r, input logic clr, input logic rd,
                        input logic [4:0] wreg, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic mdu, input logic br);
      logic lu, busy, stall, bflush;
      @(negedge clk);
      rst = r; clr_cnt = clr; ex_mem_read = rd; ex_wreg = wreg;
      id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
      id_mdu_op = mdu; id_branch_taken = br;
      if (!r) begin
         wait_left = 0; m_stall = 0; m_flush = 0;
      end
      lu     = rd && (wreg != 0) && ((urs && rs == wreg) || (urt && rt == wreg));
      busy   = r && (wait_left > 0);
      stall  = busy || lu;
      bflush = r && !stall && br;
      #1;
      if (!r) begin
         check("pc_en_rst", pc_en, 0);
         check("if_id_en_rst", if_id_en, 0);
         check("if_id_flush_rst", if_id_flush, 1);
         check("id_ex_flush_rst", id_ex_flush, 1);
         check("mdu_busy_rst", mdu_busy, 0);
      end else begin
         check("pc_en", pc_en, !stall);
         check("if_id_en", if_id_en, !stall);
         check("if_id_flush", if_id_flush, bflush);
         check("id_ex_flush", id_ex_flush, stall);
         check("mdu_busy", mdu_busy, busy);
      end
      check("stall_cnt", 32'(stall_cnt), m_stall);
      check("flush_cnt", 32'(flush_cnt), m_flush);
      if (r) begin
         if (busy) wait_left--;
         else if (!lu && mdu) wait_left = MDU_LAT;
         if (clr) begin
            m_stall = 0; m_flush = 0;
         end else begin
            if (stall && m_stall < CMAX) m_stall++;
            if (bflush && m_flush < CMAX) m_flush++;
         end
      end
   endtask

   task automatic idle();
      cycle(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
   endtask

   initial begin
      // reset held for 3 cycles, then release with no hazards
      repeat (3) cycle(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
      repeat (2) idle();
      // load-use on rs, then $zero destination must not stall
      cycle(1, 0, 1, 5'd8, 5'd8, 5'd0, 1, 0, 0, 0);
      idle();
      cycle(1, 0, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0);
      cycle(1, 0, 1, 5'd9, 5'd1, 5'd9, 0, 1, 0, 0);
      cycle(1, 0, 1, 5'd9, 5'd9, 5'd2, 0, 1, 0, 0);
      idle();
      // taken branch, then branch masked by a simultaneous load-use
      cycle(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1);
      cycle(1, 0, 1, 5'd5, 5'd5, 5'd0, 1, 0, 0, 1);
      idle();
      // single mdu op, then back-to-back ops with ID inputs noisy during the wait
      cycle(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
      repeat (5) idle();
      repeat (9) cycle(1, 0, 1, 5'd3, 5'd3, 5'd3, 1, 1, 1, 1);
      repeat (2) idle();
      // branch and mdu op together
      cycle(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1);
      repeat (5) idle();
      // reset asserted two cycles into the wait
      cycle(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
      repeat (2) idle();
      cycle(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
      repeat (3) idle();
      // saturation of stall_cnt, then clear
      repeat (20) cycle(1, 0, 1, 5'd4, 5'd0, 5'd4, 0, 1, 0, 0);
      cycle(1, 1, 1, 5'd4, 5'd0, 5'd4, 0, 1, 0, 0);
      repeat (2) idle();
      repeat (20) cycle(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1);
      // random traffic with a narrow register range to make hazards common
      for (int i = 0; i < 600; i++) begin
         cycle($urandom_range(0, 49) != 0, $urandom_range(0, 29) == 0,
               $urandom_range(0, 2) == 0, 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
